form_error_checker: RTL and testbench

//  Parametrised CAN form-error checker, successor to the fixed CRC/ACK delimiter check.

---
 rtl/form_error_checker_if.sv | 51 +++++
 rtl/form_error_checker.sv | 146 ++++++++++++++
 tb/tb_form_error_checker.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/form_error_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : form_error_checker_if
//  Description : Bus bundle between the CAN frame decoder / checker-side
//                consumer and form_error_checker.
//                Decoder-side inputs : RX, F_CRC_D, F_ACK_D, F_EOF_START, CLR
//                Checker outputs     : FORM_Error, FORM_Code[1:0],
//                                      FORM_Sticky, OVLD_Req,
//                                      FORM_Count[CNT_W-1:0] (FORM_ERR_CNT_EN)
//                Modports: master = drives decoder flags, reads status;
//                          slave  = the checker itself.
//  Macro       : FORM_ERR_CNT_EN adds FORM_Count and the CNT_W parameter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface form_error_checker_if
`ifdef FORM_ERR_CNT_EN
#(
    parameter int CNT_W = 8
)
`endif
();
    logic       RX;
    logic       F_CRC_D;
    logic       F_ACK_D;
    logic       F_EOF_START;
    logic       CLR;
    logic       FORM_Error;
    logic [1:0] FORM_Code;
    logic       FORM_Sticky;
    logic       OVLD_Req;
`ifdef FORM_ERR_CNT_EN
    logic [CNT_W-1:0] FORM_Count;
`endif

    modport master (
        output RX, F_CRC_D, F_ACK_D, F_EOF_START, CLR,
        input  FORM_Error, FORM_Code, FORM_Sticky, OVLD_Req
`ifdef FORM_ERR_CNT_EN
      , input  FORM_Count
`endif
    );

    modport slave (
        input  RX, F_CRC_D, F_ACK_D, F_EOF_START, CLR,
        output FORM_Error, FORM_Code, FORM_Sticky, OVLD_Req
`ifdef FORM_ERR_CNT_EN
      , output FORM_Count
`endif
    );
endinterface : form_error_checker_if
`default_nettype wire

// File: rtl/form_error_checker.sv
`default_nettype none
// ============================================================================
//  Module      : form_error_checker
//  Description : CAN form-error checker. On every SP rising edge it samples
//                RX and checks the CRC delimiter, the ACK delimiter and all
//                EOF_LEN bits of End-Of-Frame for the required recessive level.
//  Ports       : SP          - sample-point clock (rising edge)
//                reset       - asynchronous active-low reset
//                bus (slave) - RX / decoder flags / CLR in;
//                              FORM_Error, FORM_Code, FORM_Sticky, OVLD_Req
//                              (and FORM_Count) out, all registered
//  Parameters  : EOF_LEN (2..15), LAST_EOF_IS_ERR, CNT_W (counter builds)
//  Macro       : FORM_ERR_CNT_EN enables the saturating FORM_Count counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module form_error_checker #(
    parameter int EOF_LEN         = 7,
    parameter bit LAST_EOF_IS_ERR = 1'b0
`ifdef FORM_ERR_CNT_EN
  , parameter int CNT_W           = 8
`endif
) (
    input  wire logic         SP,
    input  wire logic         reset,
    form_error_checker_if.slave bus
);

    localparam int                 c_IDX_W    = $clog2(EOF_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(EOF_LEN - 1);

    localparam logic [1:0] c_CODE_CRC = 2'b01;
    localparam logic [1:0] c_CODE_ACK = 2'b10;
    localparam logic [1:0] c_CODE_EOF = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_EOF_CHK = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [c_IDX_W-1:0] cnt_q,    cnt_d;
    logic               err_q,    err_d;
    logic [1:0]         code_q,   code_d;
    logic               sticky_q, sticky_d;
    logic               ovld_q,   ovld_d;
`ifdef FORM_ERR_CNT_EN
    logic [CNT_W-1:0]   count_q,  count_d;
`endif

    logic               w_crc_err;
    logic               w_ack_err;
    logic               w_delim_err;
    logic               w_eof_active;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_last;
    logic               w_eof_dom;
    logic               w_eof_err;
    logic               w_any_err;

    always_comb begin
        w_crc_err    = bus.F_CRC_D & ~bus.RX;
        w_ack_err    = bus.F_ACK_D & ~bus.RX;
        w_delim_err  = w_crc_err | w_ack_err;

        // F_EOF_START always means "this is EOF bit 0", even mid-check.
        w_eof_active = bus.F_EOF_START | (state_q == S_EOF_CHK);
        w_idx        = bus.F_EOF_START ? '0 : cnt_q;
        w_last       = (w_idx == c_LAST_IDX);
        w_eof_dom    = w_eof_active & ~bus.RX;
        w_eof_err    = w_eof_dom & (~w_last | LAST_EOF_IS_ERR);
        w_any_err    = w_delim_err | w_eof_err;

        err_d        = w_any_err;
        // A delimiter error on the same bit is the reportable event; no
        // overload request is raised alongside an error.
        ovld_d       = w_eof_dom & w_last & ~LAST_EOF_IS_ERR & ~w_delim_err;

        code_d = code_q;
        if (w_crc_err) begin
            code_d = c_CODE_CRC;
        end else if (w_ack_err) begin
            code_d = c_CODE_ACK;
        end else if (w_eof_err) begin
            code_d = c_CODE_EOF;
        end

        // A fresh error beats a concurrent clear.
        sticky_d = w_any_err | (sticky_q & ~bus.CLR);

        // Any dominant EOF bit, the final EOF bit or a delimiter error ends
        // the check; only a recessive, non-final EOF bit advances it.
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!w_delim_err && w_eof_active && !w_eof_dom && !w_last) begin
            state_d = S_EOF_CHK;
            cnt_d   = w_idx + 1'b1;
        end

`ifdef FORM_ERR_CNT_EN
        count_d = count_q;
        if (w_any_err) begin
            if (bus.CLR) begin
                count_d = CNT_W'(1);
            end else if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end else if (bus.CLR) begin
            count_d = '0;
        end
`endif
    end

    always_ff @(posedge SP or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            sticky_q <= 1'b0;
            ovld_q   <= 1'b0;
`ifdef FORM_ERR_CNT_EN
            count_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            code_q   <= code_d;
            sticky_q <= sticky_d;
            ovld_q   <= ovld_d;
`ifdef FORM_ERR_CNT_EN
            count_q  <= count_d;
`endif
        end
    end

    assign bus.FORM_Error  = err_q;
    assign bus.FORM_Code   = code_q;
    assign bus.FORM_Sticky = sticky_q;
    assign bus.OVLD_Req    = ovld_q;
`ifdef FORM_ERR_CNT_EN
    assign bus.FORM_Count  = count_q;
`endif

endmodule : form_error_checker
`default_nettype wire

// File: tb/tb_form_error_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_form_error_checker
//  Description : Self-checking bench for form_error_checker. Two instances
//                share one stimulus: u_dut0 (EOF_LEN=7, LAST_EOF_IS_ERR=0,
//                CNT_W=8) and u_dut1 (EOF_LEN=7, LAST_EOF_IS_ERR=1, CNT_W=2).
//                Both are compared every edge with a frame-level reference
//                model; directed vectors also carry literal expectations.
//  Macro       : FORM_ERR_CNT_EN adds counter instances and checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_form_error_checker;

    localparam int c_EOF_LEN = 7;

    logic SP;
    logic reset;
    logic rx, crc, ack, eof, clr;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef FORM_ERR_CNT_EN
    form_error_checker_if #(.CNT_W(8)) if0 ();
    form_error_checker_if #(.CNT_W(2)) if1 ();
`else
    form_error_checker_if if0 ();
    form_error_checker_if if1 ();
`endif

    assign if0.RX = rx;  assign if0.F_CRC_D = crc;  assign if0.F_ACK_D = ack;
    assign if0.F_EOF_START = eof;  assign if0.CLR = clr;
    assign if1.RX = rx;  assign if1.F_CRC_D = crc;  assign if1.F_ACK_D = ack;
    assign if1.F_EOF_START = eof;  assign if1.CLR = clr;

    form_error_checker #(
        .EOF_LEN(c_EOF_LEN), .LAST_EOF_IS_ERR(1'b0)
`ifdef FORM_ERR_CNT_EN
      , .CNT_W(8)
`endif
    ) u_dut0 (.SP(SP), .reset(reset), .bus(if0.slave));

    form_error_checker #(
        .EOF_LEN(c_EOF_LEN), .LAST_EOF_IS_ERR(1'b1)
`ifdef FORM_ERR_CNT_EN
      , .CNT_W(2)
`endif
    ) u_dut1 (.SP(SP), .reset(reset), .bus(if1.slave));

    initial SP = 1'b0;
    always #5 SP = ~SP;

    // ---------------- reference model (per instance k) ----------------
    // m_pos: EOF bit index expected next (-1 = not inside EOF)
    int m_pos[2], m_err[2], m_code[2], m_sticky[2], m_ovld[2], m_cnt[2];

    function automatic bit last_is_err(int k); return (k == 1); endfunction
    function automatic int cnt_max(int k);     return (k == 0) ? 255 : 3; endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = -1; m_err[k] = 0; m_code[k] = 0;
            m_sticky[k] = 0; m_ovld[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge(bit i_rx, bit i_crc, bit i_ack, bit i_eof, bit i_clr);
        for (int k = 0; k < 2; k++) begin
            bit dom   = !i_rx;
            bit crc_e = i_crc && dom;
            bit ack_e = i_ack && dom;
            bit eof_e = 0;
            bit ov    = 0;
            bit err;
            int pos   = i_eof ? 0 : m_pos[k];
            if (crc_e)      m_code[k] = 1;
            else if (ack_e) m_code[k] = 2;
            else if (pos >= 0 && dom) begin
                if (pos == c_EOF_LEN - 1 && !last_is_err(k)) ov = 1;
                else begin eof_e = 1; m_code[k] = 3; end
            end
            if (crc_e || ack_e || dom || pos == c_EOF_LEN - 1) m_pos[k] = -1;
            else if (pos >= 0)                                  m_pos[k] = pos + 1;
            else                                                m_pos[k] = -1;
            err = crc_e || ack_e || eof_e;
            m_err[k]  = err;
            m_ovld[k] = ov;
            if (err) begin
                m_sticky[k] = 1;
                m_cnt[k]    = i_clr ? 1 : ((m_cnt[k] < cnt_max(k)) ? m_cnt[k] + 1 : m_cnt[k]);
            end else if (i_clr) begin
                m_sticky[k] = 0;
                m_cnt[k]    = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        check("dut0.err",    int'(if0.FORM_Error),  m_err[0]);
        check("dut0.code",   int'(if0.FORM_Code),   m_code[0]);
        check("dut0.sticky", int'(if0.FORM_Sticky), m_sticky[0]);
        check("dut0.ovld",   int'(if0.OVLD_Req),    m_ovld[0]);
        check("dut1.err",    int'(if1.FORM_Error),  m_err[1]);
        check("dut1.code",   int'(if1.FORM_Code),   m_code[1]);
        check("dut1.sticky", int'(if1.FORM_Sticky), m_sticky[1]);
        check("dut1.ovld",   int'(if1.OVLD_Req),    m_ovld[1]);
`ifdef FORM_ERR_CNT_EN
        check("dut0.count",  int'(if0.FORM_Count),  m_cnt[0]);
        check("dut1.count",  int'(if1.FORM_Count),  m_cnt[1]);
`endif
    endtask

    task automatic check_all_zero(string tag);
        check({tag, ".dut0.err"},    int'(if0.FORM_Error),  0);
        check({tag, ".dut0.code"},   int'(if0.FORM_Code),   0);
        check({tag, ".dut0.sticky"}, int'(if0.FORM_Sticky), 0);
        check({tag, ".dut0.ovld"},   int'(if0.OVLD_Req),    0);
        check({tag, ".dut1.err"},    int'(if1.FORM_Error),  0);
        check({tag, ".dut1.sticky"}, int'(if1.FORM_Sticky), 0);
`ifdef FORM_ERR_CNT_EN
        check({tag, ".dut0.count"},  int'(if0.FORM_Count),  0);
        check({tag, ".dut1.count"},  int'(if1.FORM_Count),  0);
`endif
    endtask

    // Drive inputs away from the edge, clock once, update model, sample #1 later.
    task automatic step(bit i_rx, bit i_crc, bit i_ack, bit i_eof, bit i_clr);
        rx = i_rx; crc = i_crc; ack = i_ack; eof = i_eof; clr = i_clr;
        @(posedge SP);
        model_edge(i_rx, i_crc, i_ack, i_eof, i_clr);
        #1;
        check_model();
    endtask

    // ---------------- directed vector table (literal expectations for dut0) --
    typedef struct {
        bit rx, crc, ack, eof, clr;
        bit e_err; bit [1:0] e_code; bit e_sticky, e_ovld;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(bit r, bit c, bit a, bit e, bit cl,
                                bit xe, bit [1:0] xc, bit xs, bit xo);
        vec_t v;
        v.rx = r; v.crc = c; v.ack = a; v.eof = e; v.clr = cl;
        v.e_err = xe; v.e_code = xc; v.e_sticky = xs; v.e_ovld = xo;
        vecs.push_back(v);
    endfunction

    initial begin
        //  rx crc ack eof clr | err code sticky ovld
        add(0, 1, 0, 0, 0,   1, 2'b01, 1, 0);   // CRC delimiter dominant
        add(0, 0, 1, 0, 0,   1, 2'b10, 1, 0);   // ACK delimiter dominant
        add(1, 0, 0, 0, 0,   0, 2'b10, 1, 0);   // pulse drops, code holds
        add(0, 1, 1, 0, 0,   1, 2'b01, 1, 0);   // both: CRC wins
        add(1, 0, 0, 0, 1,   0, 2'b01, 0, 0);   // CLR
        add(1, 1, 0, 0, 0,   0, 2'b01, 0, 0);   // recessive delimiter: nothing
        add(1, 0, 0, 1, 0,   0, 2'b01, 0, 0);   // clean EOF bit 0
        for (int i = 1; i < 7; i++) add(1, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        add(1, 0, 0, 1, 0,   0, 2'b01, 0, 0);   // EOF bit 0
        add(1, 0, 0, 0, 0,   0, 2'b01, 0, 0);   // bit 1
        add(1, 0, 0, 0, 0,   0, 2'b01, 0, 0);   // bit 2
        add(0, 0, 0, 0, 0,   1, 2'b11, 1, 0);   // bit 3 dominant
        for (int i = 4; i < 7; i++) add(0, 0, 0, 0, 0, 0, 2'b11, 1, 0); // ignored
        add(1, 0, 0, 1, 0,   0, 2'b11, 1, 0);   // EOF bit 0
        for (int i = 1; i < 6; i++) add(1, 0, 0, 0, 0, 0, 2'b11, 1, 0);
        add(0, 0, 0, 0, 0,   0, 2'b11, 1, 1);   // last bit dominant: overload
        add(1, 0, 0, 0, 0,   0, 2'b11, 1, 0);
        add(0, 1, 0, 0, 1,   1, 2'b01, 1, 0);   // CLR with concurrent error
        add(1, 0, 0, 1, 0,   0, 2'b01, 1, 0);   // EOF bit 0
        add(1, 0, 0, 0, 0,   0, 2'b01, 1, 0);
        add(1, 0, 0, 0, 0,   0, 2'b01, 1, 0);
        add(1, 0, 0, 1, 0,   0, 2'b01, 1, 0);   // restart at bit 0
        for (int i = 1; i < 6; i++) add(1, 0, 0, 0, 0, 0, 2'b01, 1, 0);
        add(0, 0, 0, 0, 0,   0, 2'b01, 1, 1);   // bit 6 after restart
        add(1, 0, 0, 0, 0,   0, 2'b01, 1, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        rx = 1'b1; crc = 1'b0; ack = 1'b0; eof = 1'b0; clr = 1'b0;
        reset = 1'b0;
        model_reset();
        #12;
        check_all_zero("in_reset");
        #10 reset = 1'b1;                       // released away from an edge

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        check_all_zero("idle");

        // directed table
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rx, vecs[i].crc, vecs[i].ack, vecs[i].eof, vecs[i].clr);
            check($sformatf("vec%0d.err", i),    int'(if0.FORM_Error),  int'(vecs[i].e_err));
            check($sformatf("vec%0d.code", i),   int'(if0.FORM_Code),   int'(vecs[i].e_code));
            check($sformatf("vec%0d.sticky", i), int'(if0.FORM_Sticky), int'(vecs[i].e_sticky));
            check($sformatf("vec%0d.ovld", i),   int'(if0.OVLD_Req),    int'(vecs[i].e_ovld));
        end

        // last EOF bit dominant on the LAST_EOF_IS_ERR=1 instance
        step(1, 0, 0, 1, 0);
        for (int i = 1; i < 6; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("last_err.dut1.err",  int'(if1.FORM_Error), 1);
        check("last_err.dut1.code", int'(if1.FORM_Code),  3);
        check("last_err.dut1.ovld", int'(if1.OVLD_Req),   0);
        check("last_err.dut0.err",  int'(if0.FORM_Error), 0);
        check("last_err.dut0.ovld", int'(if0.OVLD_Req),   1);

`ifdef FORM_ERR_CNT_EN
        // saturation: 5 errors after clear
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        check("sat.dut0.count", int'(if0.FORM_Count), 5);
        check("sat.dut1.count", int'(if1.FORM_Count), 3);
`endif

        // reset asserted mid-EOF (bit 4 about to be sampled dominant)
        step(0, 1, 0, 0, 0);                    // make sticky/code non-zero
        step(1, 0, 0, 1, 0);
        for (int i = 1; i < 4; i++) step(1, 0, 0, 0, 0);
        rx = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge SP);
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);  // FSM must be idle
        check_all_zero("post_rst");

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_form_error_checker
`default_nettype wire
